// File: rtl/gate_seq_pkg.sv
// Shared state encoding and reference truth tables for the gate sequencer.
package gate_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_APPLY  = 2'd1,
    S_FINISH = 2'd2
  } state_e;

  // Bit v of a table is the expected gate output when stim == v.
  localparam logic [3:0] TT_NOR2  = 4'b0001;
  localparam logic [3:0] TT_NAND2 = 4'b0111;
  localparam logic [3:0] TT_AND2  = 4'b1000;
  localparam logic [3:0] TT_OR2   = 4'b1110;
  localparam logic [1:0] TT_INV   = 2'b01;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/gate_seq_timer.sv
// Per-vector hold counter: counts 0..HOLD_CYCLES-1 while enabled, tc flags the last hold cycle.
module gate_seq_timer
  import gate_seq_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned W = cnt_width(HOLD_CYCLES);
  localparam logic [W-1:0] TC_VAL = W'(HOLD_CYCLES - 1);

  logic [W-1:0] hold_q, hold_d;

  // Wraps to 0 on the last hold cycle so the next vector starts fresh.
  always_comb begin
    hold_d = hold_q;
    if (clr) begin
      hold_d = '0;
    end else if (en) begin
      hold_d = (hold_q == TC_VAL) ? '0 : hold_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end

  assign tc = (hold_q == TC_VAL);

endmodule

// File: rtl/gate_seq_ctrl.sv
// Exhaustive stimulus/compare sequencer for a small combinational gate.
// Optional first-failure capture ports are built when GATE_SEQ_FIRST_FAIL_EN is defined.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for start; stim, pass and err_cnt hold last result
// S_APPLY  | driving stim=vec, comparing y_dut on each vector's last hold cycle
// S_FINISH | one-cycle done pulse, then back to idle
module gate_seq_ctrl
  import gate_seq_pkg::*;
#(
  parameter int unsigned       N_IN        = 2,
  parameter int unsigned       HOLD_CYCLES = 10,
  parameter logic [2**N_IN-1:0] TT         = TT_NOR2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic [N_IN-1:0]                stim,
  input  logic                           y_dut,
  output logic                           busy,
  output logic                           done,
  output logic                           pass,
  output logic [$clog2(2**N_IN+1)-1:0]   err_cnt
`ifdef GATE_SEQ_FIRST_FAIL_EN
  ,
  output logic                           fail_vld,
  output logic [N_IN-1:0]                fail_vec
`endif
);

  localparam int unsigned NV = 2**N_IN;
  localparam int unsigned EW = $clog2(NV + 1);
  localparam logic [N_IN-1:0] VEC_LAST = N_IN'(NV - 1);

  state_e          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [EW-1:0]   err_cnt_q, err_cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;

  logic            accept;
  logic            tc;
  logic            sample;
  logic            mismatch;
  logic [EW-1:0]   err_inc;

  assign accept   = (state_q == S_IDLE) && start;
  assign sample   = (state_q == S_APPLY) && tc;
  assign mismatch = sample && (y_dut != TT[vec_q]);
  // Count including this cycle's mismatch so the final verdict sees it.
  assign err_inc  = err_cnt_q + EW'(mismatch);

  gate_seq_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (state_q == S_APPLY),
    .tc  (tc)
  );

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    err_cnt_d = err_cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_APPLY;
          vec_d     = '0;
          err_cnt_d = '0;
          pass_d    = 1'b0;
          busy_d    = 1'b1;
        end
      end
      S_APPLY: begin
        if (sample) begin
          err_cnt_d = err_inc;
          if (vec_q == VEC_LAST) begin
            state_d = S_FINISH;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_inc == '0);
          end else begin
            vec_d = vec_q + N_IN'(1);
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      vec_q     <= '0;
      err_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      err_cnt_q <= err_cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  // vec stops at the last vector, so stim keeps all-ones after a run.
  assign stim    = vec_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign err_cnt = err_cnt_q;

`ifdef GATE_SEQ_FIRST_FAIL_EN
  logic            fail_vld_q, fail_vld_d;
  logic [N_IN-1:0] fail_vec_q, fail_vec_d;

  always_comb begin
    fail_vld_d = fail_vld_q;
    fail_vec_d = fail_vec_q;
    if (accept) begin
      fail_vld_d = 1'b0;
      fail_vec_d = '0;
    end else if (mismatch && !fail_vld_q) begin
      fail_vld_d = 1'b1;
      fail_vec_d = vec_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fail_vld_q <= 1'b0;
      fail_vec_q <= '0;
    end else begin
      fail_vld_q <= fail_vld_d;
      fail_vec_q <= fail_vec_d;
    end
  end

  assign fail_vld = fail_vld_q;
  assign fail_vec = fail_vec_q;
`endif

endmodule

// File: tb/tb_gate_seq_ctrl.sv
// Directed bench for gate_seq_ctrl: NOR2/H=10 instance plus a NAND2/H=1 instance.
module tb_gate_seq_ctrl;
  import gate_seq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_a, start_b;
  int         mode;
  logic       y_a, y_b;
  logic [1:0] stim_a, stim_b;
  logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [2:0] err_a, err_b;
`ifdef GATE_SEQ_FIRST_FAIL_EN
  logic       fvld_a, fvld_b;
  logic [1:0] fvec_a, fvec_b;
`endif

  // mode 0: good NOR2, 1: output stuck at 0, 2: NAND2 wired where NOR2 belongs
  always_comb begin
    case (mode)
      0:       y_a = ~(stim_a[1] | stim_a[0]);
      1:       y_a = 1'b0;
      default: y_a = ~(stim_a[1] & stim_a[0]);
    endcase
  end
  assign y_b = ~(stim_b[1] & stim_b[0]);

  gate_seq_ctrl #(.N_IN(2), .HOLD_CYCLES(10), .TT(TT_NOR2)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .stim(stim_a), .y_dut(y_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a)
`ifdef GATE_SEQ_FIRST_FAIL_EN
    , .fail_vld(fvld_a), .fail_vec(fvec_a)
`endif
  );

  gate_seq_ctrl #(.N_IN(2), .HOLD_CYCLES(1), .TT(TT_NAND2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .stim(stim_b), .y_dut(y_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b)
`ifdef GATE_SEQ_FIRST_FAIL_EN
    , .fail_vld(fvld_b), .fail_vec(fvec_b)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full run on dut_a; cycle 1 is the cycle after the edge that samples start.
  task automatic run_a(input string name, input bit repulse, input logic [2:0] exp_err,
                       input logic exp_pass, input logic [1:0] exp_fvec);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      chk({name, ".busy"}, busy_a, 1);
      chk({name, ".stim"}, stim_a, (cyc - 1) / 10);
      chk({name, ".done_early"}, done_a, 0);
      start_a = repulse && (cyc == 5 || cyc == 20);
      step();
    end
    start_a = 1'b0;
    chk({name, ".done41"}, done_a, 1);
    chk({name, ".busy41"}, busy_a, 0);
    chk({name, ".pass"}, pass_a, exp_pass);
    chk({name, ".err_cnt"}, err_a, exp_err);
    chk({name, ".stim_hold"}, stim_a, 3);
`ifdef GATE_SEQ_FIRST_FAIL_EN
    chk({name, ".fail_vld"}, fvld_a, (exp_err != 0));
    chk({name, ".fail_vec"}, fvec_a, exp_fvec);
`endif
    for (int k = 0; k < 5; k++) begin
      step();
      chk({name, ".done_after"}, done_a, 0);
      chk({name, ".busy_after"}, busy_a, 0);
      chk({name, ".stim_after"}, stim_a, 3);
      chk({name, ".pass_after"}, pass_a, exp_pass);
    end
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    mode = 0;
    step();
    step();
    rst = 1'b0;
    chk("rst.stim", stim_a, 0);
    chk("rst.busy", busy_a, 0);
    chk("rst.done", done_a, 0);
    chk("rst.pass", pass_a, 0);
    chk("rst.err", err_a, 0);
    chk("rst.b_busy", busy_b, 0);
`ifdef GATE_SEQ_FIRST_FAIL_EN
    chk("rst.fail_vld", fvld_a, 0);
    chk("rst.fail_vec", fvec_a, 0);
`endif
    step();

    mode = 0;
    run_a("t1_nor", 1'b0, 3'd0, 1'b1, 2'b00);

    mode = 1;
    run_a("t2_stuck0", 1'b0, 3'd1, 1'b0, 2'b00);

    // NAND vs NOR table: mismatches on 01 and 10
    mode = 2;
    run_a("t3_wrong_gate", 1'b0, 3'd2, 1'b0, 2'b01);

    mode = 0;
    run_a("t4_repulse", 1'b1, 3'd0, 1'b1, 2'b00);

    // Stuck-at-0 run gives err_cnt=1 by cycle 15, then reset mid-run.
    mode = 1;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int cyc = 1; cyc < 15; cyc++) step();
    chk("t5.err_before_rst", err_a, 1);
    chk("t5.stim_before_rst", stim_a, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5.stim", stim_a, 0);
    chk("t5.busy", busy_a, 0);
    chk("t5.err", err_a, 0);
    chk("t5.pass", pass_a, 0);
    chk("t5.done", done_a, 0);
    for (int k = 0; k < 40; k++) begin
      step();
      chk("t5.no_done", done_a, 0);
      chk("t5.idle", busy_a, 0);
    end
    mode = 0;
    run_a("t5_rerun", 1'b0, 3'd0, 1'b1, 2'b00);

    start_b = 1'b1;
    step();
    start_b = 1'b0;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      chk("t6.busy", busy_b, 1);
      chk("t6.stim", stim_b, cyc - 1);
      chk("t6.done_early", done_b, 0);
      step();
    end
    chk("t6.done5", done_b, 1);
    chk("t6.pass5", pass_b, 1);
    chk("t6.err5", err_b, 0);
    start_b = 1'b1;
    step();
    chk("t6.ignored_busy", busy_b, 0);
    chk("t6.ignored_done", done_b, 0);
    step();
    start_b = 1'b0;
    for (int cyc = 7; cyc <= 10; cyc++) begin
      chk("t6.rerun_busy", busy_b, 1);
      chk("t6.rerun_stim", stim_b, cyc - 7);
      step();
    end
    chk("t6.done11", done_b, 1);
    chk("t6.pass11", pass_b, 1);
    step();
    chk("t6.done12", done_b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
